// File: rtl/ghost_mode_sequencer_if.sv
// Bundles the sequencer's game-side inputs and the ghost-mode outputs.
// GHOST_MODE_REVERSE_EN adds the reverse_pulse output.
interface ghost_mode_sequencer_if;
  logic       vsync_enable;
  logic       pause;
  logic       stall;
  logic       power_pellet;
  logic       pacman_dead;
  logic       end_of_game;
  logic       chase;
  logic       scared_mode;
  logic       scared_mode_end;
  logic       scared_start;
  logic [2:0] phase_idx;
`ifdef GHOST_MODE_REVERSE_EN
  logic       reverse_pulse;

  modport master (
    output vsync_enable, pause, stall, power_pellet, pacman_dead, end_of_game,
    input  chase, scared_mode, scared_mode_end, scared_start, phase_idx, reverse_pulse
  );
  modport slave (
    input  vsync_enable, pause, stall, power_pellet, pacman_dead, end_of_game,
    output chase, scared_mode, scared_mode_end, scared_start, phase_idx, reverse_pulse
  );
`else
  modport master (
    output vsync_enable, pause, stall, power_pellet, pacman_dead, end_of_game,
    input  chase, scared_mode, scared_mode_end, scared_start, phase_idx
  );
  modport slave (
    input  vsync_enable, pause, stall, power_pellet, pacman_dead, end_of_game,
    output chase, scared_mode, scared_mode_end, scared_start, phase_idx
  );
`endif
endinterface

// File: rtl/ghost_mode_sequencer.sv
// Global scatter/pursuit schedule and frightened timer shared by all four ghosts.
// Define GHOST_MODE_REVERSE_EN to drive reverse_pulse on phase changes and fright entry.
module ghost_mode_sequencer #(
  parameter int unsigned SCATTER_FRAMES    = 420,
  parameter int unsigned PURSUIT_FRAMES    = 1200,
  parameter int unsigned NUM_PHASES        = 8,
  parameter int unsigned SCARED_FRAMES     = 360,
  parameter int unsigned SCARED_END_FRAMES = 120,
  parameter int unsigned CNT_W             = 11
) (
  input logic                   clk,
  input logic                   reset,
  ghost_mode_sequencer_if.slave bus
);

  typedef enum logic [0:0] {StSched, StFright} state_e;

  localparam logic [CNT_W-1:0] ScatterLast = CNT_W'(SCATTER_FRAMES - 1);
  localparam logic [CNT_W-1:0] PursuitLast = CNT_W'(PURSUIT_FRAMES - 1);
  localparam logic [CNT_W-1:0] ScaredLast  = CNT_W'(SCARED_FRAMES - 1);
  localparam logic [CNT_W-1:0] EndFrom     = CNT_W'(SCARED_FRAMES - SCARED_END_FRAMES);
  localparam logic [2:0]       PhaseLast   = 3'(NUM_PHASES - 1);

  state_e           r_state,        w_state_nxt;
  logic [2:0]       r_phase_idx,    w_phase_idx_nxt;
  logic [CNT_W-1:0] r_phase_cnt,    w_phase_cnt_nxt;
  logic [CNT_W-1:0] r_fright_cnt,   w_fright_cnt_nxt;
  logic             r_scared_start, w_scared_start_nxt;
  logic             r_reverse,      w_reverse_nxt;

  logic             w_pause_en;
  logic             w_tick;
  logic             w_clear;
  logic [CNT_W-1:0] w_phase_last;

  assign w_pause_en   = bus.pause | bus.stall;
  assign w_tick       = bus.vsync_enable & ~w_pause_en;
  assign w_clear      = bus.pacman_dead | bus.end_of_game;
  assign w_phase_last = r_phase_idx[0] ? PursuitLast : ScatterLast;

  always_comb begin
    w_state_nxt        = r_state;
    w_phase_idx_nxt    = r_phase_idx;
    w_phase_cnt_nxt    = r_phase_cnt;
    w_fright_cnt_nxt   = r_fright_cnt;
    w_scared_start_nxt = 1'b0;
    w_reverse_nxt      = 1'b0;

    if (w_clear) begin
      w_state_nxt      = StSched;
      w_phase_idx_nxt  = '0;
      w_phase_cnt_nxt  = '0;
      w_fright_cnt_nxt = '0;
    end else if (bus.power_pellet && !w_pause_en) begin
      // Pellet restarts fright and swallows a coincident tick.
      w_state_nxt        = StFright;
      w_fright_cnt_nxt   = '0;
      w_scared_start_nxt = 1'b1;
      w_reverse_nxt      = 1'b1;
    end else if (w_tick) begin
      unique case (r_state)
        StSched: begin
          if (r_phase_idx != PhaseLast) begin
            if (r_phase_cnt == w_phase_last) begin
              w_phase_cnt_nxt = '0;
              w_phase_idx_nxt = r_phase_idx + 3'd1;
              w_reverse_nxt   = 1'b1;
            end else begin
              w_phase_cnt_nxt = r_phase_cnt + 1'b1;
            end
          end
        end
        StFright: begin
          if (r_fright_cnt == ScaredLast) begin
            w_state_nxt      = StSched;
            w_fright_cnt_nxt = '0;
          end else begin
            w_fright_cnt_nxt = r_fright_cnt + 1'b1;
          end
        end
        default: w_state_nxt = StSched;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StSched;
      r_phase_idx    <= '0;
      r_phase_cnt    <= '0;
      r_fright_cnt   <= '0;
      r_scared_start <= 1'b0;
      r_reverse      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_phase_idx    <= w_phase_idx_nxt;
      r_phase_cnt    <= w_phase_cnt_nxt;
      r_fright_cnt   <= w_fright_cnt_nxt;
      r_scared_start <= w_scared_start_nxt;
      r_reverse      <= w_reverse_nxt;
    end
  end

  // The final phase is permanent pursuit even when its index is even.
  assign bus.chase           = ~r_phase_idx[0] & (r_phase_idx != PhaseLast);
  assign bus.scared_mode     = (r_state == StFright);
  assign bus.scared_mode_end = (r_state == StFright) & (r_fright_cnt >= EndFrom);
  assign bus.scared_start    = r_scared_start;
  assign bus.phase_idx       = r_phase_idx;

`ifdef GHOST_MODE_REVERSE_EN
  assign bus.reverse_pulse = r_reverse;
`else
  logic w_unused;
  assign w_unused = r_reverse;
`endif

endmodule

// File: tb/tb_ghost_mode_sequencer.sv
// Directed, table-driven bench for ghost_mode_sequencer with a shortened schedule
// (scatter 4, pursuit 6, 4 phases, fright 5, ending 2).
module tb_ghost_mode_sequencer;

  logic clk;
  logic reset;

  ghost_mode_sequencer_if bus ();

  ghost_mode_sequencer #(
    .SCATTER_FRAMES   (4),
    .PURSUIT_FRAMES   (6),
    .NUM_PHASES       (4),
    .SCARED_FRAMES    (5),
    .SCARED_END_FRAMES(2),
    .CNT_W            (11)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       pause;
    logic       stall;
    logic       pp;
    logic       dead;
    logic       eog;
    int         n;
    logic [2:0] phase;
    logic       chase;
    logic       scared;
    logic       send;
    logic       start;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic tk, input logic pa, input logic st, input logic pp,
                              input logic dd, input logic eg, input int n,
                              input logic [2:0] ph, input logic ch, input logic sc,
                              input logic se, input logic ss);
    vec_t v;
    v.tick = tk; v.pause = pa; v.stall = st; v.pp = pp; v.dead = dd; v.eog = eg;
    v.n = n; v.phase = ph; v.chase = ch; v.scared = sc; v.send = se; v.start = ss;
    return v;
  endfunction

  task automatic drive(input logic tk, input logic pa, input logic st, input logic pp,
                       input logic dd, input logic eg);
    bus.vsync_enable = tk;
    bus.pause        = pa;
    bus.stall        = st;
    bus.power_pellet = pp;
    bus.pacman_dead  = dd;
    bus.end_of_game  = eg;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] ph, input logic ch,
                            input logic sc, input logic se, input logic ss);
    check({tag, ".phase_idx"},       int'(bus.phase_idx),       int'(ph));
    check({tag, ".chase"},           int'(bus.chase),           int'(ch));
    check({tag, ".scared_mode"},     int'(bus.scared_mode),     int'(sc));
    check({tag, ".scared_mode_end"}, int'(bus.scared_mode_end), int'(se));
    check({tag, ".scared_start"},    int'(bus.scared_start),    int'(ss));
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.tick, v.pause, v.stall, v.pp, v.dead, v.eog);
    repeat (v.n) @(posedge clk);
    #1;
    check_outs($sformatf("vec%0d", idx), v.phase, v.chase, v.scared, v.send, v.start);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    //          tk pa st pp dd eg   n  ph ch sc se ss
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   1, 1, 0, 1, 0, 1));  // fright entry
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   2, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 1, 1, 0));  // 3rd fright tick
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  20, 1, 0, 1, 1, 0));  // paused
    vecs.push_back(mk(0, 1, 0, 1, 0, 0,   1, 1, 0, 1, 1, 0));  // pellet ignored
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,   3, 1, 0, 1, 1, 0));  // stalled
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 1, 1, 0));  // fright_cnt 4
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   1, 1, 0, 1, 0, 1));  // restart
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   4, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0));  // fright over
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  20, 2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   3, 2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 100, 3, 0, 0, 0, 0));  // saturated
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   1, 3, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 3, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,   1, 0, 1, 0, 0, 0));  // death beats pellet
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,   1, 0, 1, 1, 0, 1));  // pellet drops tick
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   2, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0));  // game over clears
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0));

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reach phase 2, enter fright, then hit reset between clock edges.
    apply(mk(1, 0, 0, 0, 0, 0, 6, 2, 1, 0, 0, 0), 100);
    apply(mk(0, 0, 0, 1, 0, 0, 1, 2, 1, 1, 0, 1), 101);
    apply(mk(1, 0, 0, 0, 0, 0, 4, 2, 1, 1, 1, 0), 102);
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply(mk(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0), 103);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ghost_mode_sequencer.md
Name: ghost_mode_sequencer

Overview:
Global ghost-behaviour timer that sits directly upstream of the four ghost controllers (blinky/pinky/inky/clyde).
- Produces the chase/scatter phase flag, the frightened (scared) flag, and the frightened-ending warning consumed by every ghost FSM and pixel stage.
- Counts video frames (vsync_enable ticks), freezes on pause/stall, and restarts its schedule on pacman death or end of game.

Parameters:
SCATTER_FRAMES, 420, frames per corner-targeting phase (even phase_idx).
PURSUIT_FRAMES, 1200, frames per pursuit phase (odd phase_idx).
NUM_PHASES, 8, number of scheduled phases; the final phase (NUM_PHASES-1) is permanent pursuit.
SCARED_FRAMES, 360, frightened duration in frames.
SCARED_END_FRAMES, 120, trailing frightened frames flagged as ending; must be less than SCARED_FRAMES.
CNT_W, 11, width of frame counters; must hold max(SCATTER_FRAMES, PURSUIT_FRAMES, SCARED_FRAMES).

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high; clock clk
vsync_enable  input  1  one-clk frame tick
pause  input  1  game paused
stall  input  1  game stalled (death/intro animation)
power_pellet  input  1  one-clk pulse: pacman ate energizer
pacman_dead  input  1  level restart request (level-sensitive)
end_of_game  input  1  game over (level-sensitive)
chase  output  1  1 = ghosts target home corners (scatter phase); 0 = pursue pacman
scared_mode  output  1  frightened active
scared_mode_end  output  1  frightened in final SCARED_END_FRAMES frames
scared_start  output  1  one-clk pulse on frightened entry or restart
phase_idx  output  3  current schedule phase, saturates at NUM_PHASES-1

Behaviour:
- Reset values: phase_idx=0, chase=1, scared_mode=0, scared_mode_end=0, scared_start=0. Phase counter and fright counter are 0.
- Definitions:
  - pause_en = pause | stall.
  - tick = vsync_enable & !pause_en.
- Priority per clk, highest first:
  1. reset.
  2. pacman_dead | end_of_game: synchronous return to reset values. An incoming power_pellet is ignored in that cycle.
  3. power_pellet & !pause_en: enter or restart FRIGHT. fright_cnt=0, scared_start=1 for this cycle only. Wins over a coincident tick, which is dropped for the fright counter.
  4. tick: advance whichever timer the state selects.
- States:
  - SCHED: phase timer runs.
  - FRIGHT: phase timer frozen; phase_idx and phase counter hold.
- SCHED on tick:
  - Limit L = SCATTER_FRAMES if phase_idx is even, else PURSUIT_FRAMES.
  - If phase_cnt == L-1: phase_cnt=0 and phase_idx increments.
  - Otherwise phase_cnt increments.
  - When phase_idx == NUM_PHASES-1, the timer stops and phase_cnt holds.
- chase, combinational from registered state:
  - 1 when phase_idx is even and phase_idx != NUM_PHASES-1.
  - 0 otherwise.
  - chase keeps its SCHED value throughout FRIGHT.
- FRIGHT on tick:
  - If fright_cnt == SCARED_FRAMES-1: return to SCHED, fright_cnt=0.
  - Otherwise fright_cnt increments.
- scared_mode = (state == FRIGHT).
- scared_mode_end = FRIGHT & (fright_cnt >= SCARED_FRAMES-SCARED_END_FRAMES).
- Latency: every output changes on the clk edge following the triggering input cycle.
- Counters never wrap. Equality compares use the CNT_W-bit width.
- While pause_en is high, every counter, state and output holds, except that pacman_dead or end_of_game still clears.
- Reset asserted mid-FRIGHT: all outputs return to reset values asynchronously.

Optional Feature:
GHOST_MODE_REVERSE_EN
- With the macro: adds output reverse_pulse (1 bit, reset 0). It pulses one clk on every SCHED phase_idx increment and on every scared_start, for ghost FSMs to force a 180-degree turn.
- Without the macro: the reverse_pulse port and its logic are absent.

Test Plan:
All tests use SCATTER_FRAMES=4, PURSUIT_FRAMES=6, NUM_PHASES=4, SCARED_FRAMES=5, SCARED_END_FRAMES=2.
1. Schedule: tick every 10 clks, no other stimulus -> phase_idx goes 0→1 after 4 ticks, 1→2 after 6 more, 2→3 after 4 more. chase goes 1,0,1,0 and stays 0 after 100 further ticks.
2. Fright: power_pellet in phase 1 after 2 ticks -> scared_start one clk, scared_mode=1. scared_mode_end=1 from the 3rd fright tick. scared_mode=0 after the 5th. Phase 1 then needs exactly 4 more ticks to reach phase_idx=2.
3. Fright restart: second power_pellet at fright_cnt=4 -> scared_start pulses, scared_mode_end drops to 0, frightened lasts 5 more ticks.
4. Pause: pause=1 for 20 ticks mid-phase and mid-fright -> phase_idx, counters and scared flags unchanged. power_pellet during pause is ignored.
5. Collisions: power_pellet with pacman_dead in the same clk -> phase_idx=0, chase=1, scared_mode=0, no scared_start. power_pellet with tick -> fright_cnt=0.
6. Async reset during FRIGHT at phase 2 -> immediately phase_idx=0, chase=1, scared_mode=0, scared_mode_end=0.
